popcount_seq_ctrl: RTL and testbench
====================================

Name: popcount_seq_ctrl

Overview:
Sequencer that time-shares one 8-input ones-counter to compute the population count of a wide word. It accepts a DATA_W-bit word over a valid/ready handshake and feeds it to the counter one 8-bit chunk per cycle, least-significant chunk first. It accumulates the partial counts and presents the total over a second valid/ready handshake. It sits between a word producer and any consumer of bit-weight results, such as parity or Hamming-distance logic.

Parameters:
DATA_W, 32, input word width; must be a multiple of 8 and at least 8.
NCHUNK, DATA_W/8, derived localparam; number of RUN cycles per word.
CNT_W, $clog2(DATA_W+1), derived localparam; result width (6 when DATA_W=32).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous abort; discards any word in progress.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  block can accept a word.
in_data  input  DATA_W  word to count.
out_valid  output  1  out_count holds a valid result.
out_ready  input  1  consumer accepts the result.
out_count  output  CNT_W  number of 1 bits in the accepted word.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; word register, chunk index and accumulator cleared.
  - Output values during reset: in_ready=0, out_valid=0, out_count=0, busy=0.
  - First cycle after deassertion: in_ready=1.
- Reset mid-operation discards the word; no partial result is ever presented.
- States and transitions:
  - IDLE: in_ready=1.
    - On in_valid&&in_ready: latch in_data, clear accumulator, chunk index=0, go to RUN.
  - RUN: in_ready=0, busy=1.
    - Each cycle, chunk[idx] = word[8*idx+7 : 8*idx] drives the ones-counter combinationally.
    - Accumulator += chunk count (zero-extended to CNT_W); idx increments.
    - After chunk NCHUNK-1 is accumulated, go to DONE.
  - DONE: out_valid=1, out_count = accumulator, held stable while out_ready=0.
    - On out_valid&&out_ready: go to IDLE.
- Timing:
  - Accept in cycle T; RUN occupies T+1..T+NCHUNK; out_valid is first high in T+NCHUNK+1.
  - Accept-to-result latency is NCHUNK+1 cycles; for DATA_W=8 it is 2 cycles.
  - Minimum word period is NCHUNK+2 cycles (no accept in DONE, even on the result handshake cycle).
- Arithmetic:
  - Chunk counter result is 4 bits (0..8).
  - Accumulator is CNT_W bits, sized so it cannot overflow (maximum DATA_W).
  - out_count is registered (not combinational from the counter).
- flush:
  - In RUN or DONE: go to IDLE next cycle and clear the accumulator.
  - out_valid drops the next cycle; a result being handshaken in the same cycle as flush counts as delivered.
  - In IDLE, flush has priority over acceptance: in_ready is forced to 0 in that cycle.
- in_data is sampled only on the accept cycle; later changes have no effect.
- in_valid is ignored outside IDLE.
- out_ready is ignored outside DONE.

Decomposition:
- Package popcount_pkg:
  - state enum {IDLE, RUN, DONE} (2 bits)
  - CHUNK_W=8
  - CHUNK_CNT_W=4
- Sub-module ones_count8: combinational 8-input ones-counter built from full/half adders; 8 inputs, 4-bit count.
- The controller instantiates exactly one ones_count8 and owns the FSM, chunk mux, index counter and accumulator.

Test Plan:
- DATA_W=32, accept 0xFFFF_FFFF at cycle T, out_ready=1 -> out_valid first high at T+5, out_count=32, in_ready high again at T+6.
- Accept 0x0000_0000, then immediately 0x8000_0001 -> results 0 and 2 in order; in_ready low throughout RUN and DONE.
- Accept 0x0F0F_00FF; hold out_ready=0 for 4 cycles after out_valid -> out_count stays 16, in_valid pulses ignored, single handshake when out_ready rises.
- Accept 0xFFFF_FFFF, assert flush at T+2 -> IDLE at T+3, no out_valid ever; next word 0x0000_0003 yields 2.
- Drop rst_n asynchronously at T+3 during RUN -> out_valid=0, out_count=0, busy=0 immediately; after release, in_ready=1 and the next word 0xAAAA_AAAA yields 16.
- DATA_W=8 build: accept 0xB5 -> out_count=5 with 2-cycle latency.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and sizes for the chunked population-count sequencer.
// Also holds the single-bit adder cells the ones-counter is built from.
`timescale 1ns/1ps
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CHUNK_W     = 8;
  localparam int CHUNK_CNT_W = 4;

  // Returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  function automatic logic [1:0] half_add(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/ones_count8.sv
// Combinational 8-input ones-counter (0..8) built as a small adder tree.
`timescale 1ns/1ps
module ones_count8
  import popcount_pkg::*;
(
  input  logic [CHUNK_W-1:0]     bits,
  output logic [CHUNK_CNT_W-1:0] count
);

  logic s0, c0, s1, c1, s2, c2;
  logic s3, c3, s4, c4, c5;
  logic b1, b2, b3;

  // First layer: reduce eight weight-1 bits to three weight-1 sums and three weight-2 carries.
  assign {c0, s0} = full_add(bits[0], bits[1], bits[2]);
  assign {c1, s1} = full_add(bits[3], bits[4], bits[5]);
  assign {c2, s2} = half_add(bits[6], bits[7]);

  assign {c3, s3} = full_add(s0, s1, s2);
  assign {c4, s4} = full_add(c0, c1, c2);
  assign {c5, b1} = half_add(s4, c3);
  assign {b3, b2} = half_add(c4, c5);

  assign count = {b3, b2, b1, s3};

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Time-shares one ones_count8 across the 8-bit chunks of a wide word,
// LSB chunk first, and presents the accumulated total over valid/ready.
`timescale 1ns/1ps
module popcount_seq_ctrl
  import popcount_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  acc_q, acc_d;

  logic [CHUNK_W-1:0]     chunk;
  logic [CHUNK_CNT_W-1:0] chunk_cnt;
  logic                   last_chunk;

  // rst_n gates in_ready so it reads 0 while reset is held, even though state is already IDLE.
  assign in_ready  = rst_n && (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign out_count = acc_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) chunk = word_q[i*CHUNK_W +: CHUNK_W];
    end
  end

  ones_count8 u_ones_count8 (
    .bits  (chunk),
    .count (chunk_cnt)
  );

  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    acc_d   = acc_q;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          acc_d = '0;
        end else if (in_valid && in_ready) begin
          word_d  = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = acc_q + CNT_W'(chunk_cnt);
          idx_d = idx_q + IDX_W'(1);
          if (last_chunk) state_d = DONE;
        end
      end
      DONE: begin
        if (flush) begin
          acc_d   = '0;
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Scoreboard bench for popcount_seq_ctrl: directed cases from the block's
// contract, randomized words with consumer back-pressure, and a DATA_W=8 instance.
`timescale 1ns/1ps
module tb_popcount_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int NCHUNK = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b1;
  logic              in_ready, out_valid, busy;
  logic [CNT_W-1:0]  out_count;

  logic       in_valid8 = 1'b0;
  logic [7:0] in_data8 = '0;
  logic       out_ready8 = 1'b1;
  logic       in_ready8, out_valid8, busy8;
  logic [3:0] out_count8;

  popcount_seq_ctrl #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  popcount_seq_ctrl #(.DATA_W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_count (out_count8),
    .busy      (busy8)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int handshakes = 0;
  int exp_q[$];
  bit stall_prev = 1'b0;
  logic [CNT_W-1:0] stall_val = '0;
  bit rand_on = 1'b0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int ref_popcount(input logic [DATA_W-1:0] w);
    int n = 0;
    for (int i = 0; i < DATA_W; i++) n += int'(w[i]);
    return n;
  endfunction

  // Monitor: compares each delivered result against the oldest expected count.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !busy && !flush);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          if (stall_prev) check("stall_hold", out_count, stall_val);
          if (out_ready) begin
            check("result", out_count, exp_q.pop_front());
            handshakes++;
            stall_prev = 1'b0;
          end else begin
            stall_prev = 1'b1;
            stall_val  = out_count;
          end
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] w);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_popcount(w));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    check("accept_timeout", done, 1'b1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check("drain_timeout", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    bit seen;
    logic [DATA_W-1:0] w;

    // Reset values while rst_n is held low.
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_count", out_count, 0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // All ones: latency and in_ready re-open timing.
    send('1);
    for (int k = 1; k <= NCHUNK + 2; k++) begin
      @(negedge clk);
      if (k <= NCHUNK) begin
        check("run_busy", busy, 1'b1);
        check("run_no_valid", out_valid, 1'b0);
      end else if (k == NCHUNK + 1) begin
        check("latency_valid", out_valid, 1'b1);
      end else begin
        check("reopen_in_ready", in_ready, 1'b1);
        check("reopen_no_valid", out_valid, 1'b0);
      end
    end
    @(posedge clk);
    #1;

    // Back-to-back words, results in order.
    send('0);
    send(32'h8000_0001);
    wait_idle();

    // Consumer stall with ignored in_valid pulses.
    out_ready = 1'b0;
    send(32'h0F0F_00FF);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("stall_valid_seen", seen, 1'b1);
    hs0 = handshakes;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      check("stall_count", out_count, 16);
      check("stall_out_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_released", out_valid, 1'b0);
    check("single_handshake", handshakes - hs0, 1);
    check("pulses_ignored", busy, 1'b0);
    @(posedge clk);
    #1;

    // Flush in IDLE blocks acceptance.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = '1;
    @(negedge clk);
    check("idle_flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_flush_no_accept", busy, 1'b0);
    @(posedge clk);
    #1;

    // Flush mid-RUN discards the word.
    send('1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(32'h0000_0003);
    wait_idle();

    // Asynchronous reset mid-RUN.
    send(32'h1234_5678);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_count", out_count, 0);
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("arst_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(32'hAAAA_AAAA);
    wait_idle();

    // DATA_W=8 instance: 0xB5 -> 5 with 2-cycle latency.
    in_valid8 = 1'b1;
    in_data8  = 8'hB5;
    @(negedge clk);
    check("w8_in_ready", in_ready8, 1'b1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    in_data8  = 8'h00;
    @(negedge clk);
    check("w8_run_no_valid", out_valid8, 1'b0);
    check("w8_run_busy", busy8, 1'b1);
    @(negedge clk);
    check("w8_valid", out_valid8, 1'b1);
    check("w8_count", out_count8, 5);
    @(negedge clk);
    check("w8_done", out_valid8, 1'b0);
    @(posedge clk);
    #1;

    // Randomized words with random consumer back-pressure.
    rand_on = 1'b1;
    fork
      begin
        forever begin
          @(posedge clk);
          #1;
          if (!rand_on) break;
          out_ready = ($urandom % 3) != 0;
        end
      end
    join_none
    for (int n = 0; n < 40; n++) begin
      case ($urandom % 4)
        0: w = {$urandom};
        1: w = '1;
        2: w = DATA_W'(1) << ($urandom % DATA_W);
        default: w = {$urandom} & {$urandom} & {$urandom};
      endcase
      send(w);
    end
    wait_idle();
    rand_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
